run_sequencer: RTL and testbench
================================

# run_sequencer

Host-side run sequencer for the accumulator core. It preloads operand bytes into data memory and pulses the core's `start`. It then waits for `done`, guarded by an optional watchdog, and streams a fixed window of result bytes back out of data memory. It drives the opposite end of the core's start/done handshake and shares the data-memory port with the core while the core is idle.

## Interface
- `RES_BASE`, 8'd64: first data-memory address of the result window.
- `RES_COUNT`, 8: number of result bytes streamed out (1–255).
- `START_CYCLES`, 2: width of the `core_start` pulse in cycles (≥1).
- `TIMEOUT`, 4096: maximum RUN cycles before fault (16-bit counter).

Ports:
- `clk` in 1: clock, all state on rising edge.
- `reset` in 1: asynchronous, active-high.
- `load_valid` in 1: host preload byte offered.
- `load_ready` out 1: preload accepted this cycle when high with `load_valid`.
- `load_addr` in 8: preload address.
- `load_data` in 8: preload byte.
- `go` in 1: begin run (level sampled in IDLE).
- `mem_we` out 1: data-memory write enable.
- `mem_re` out 1: data-memory read enable.
- `mem_addr` out 8: data-memory address.
- `mem_wdata` out 8: data-memory write data.
- `mem_rdata` in 8: data-memory read data, combinational from `mem_addr`.
- `core_start` out 1: core start/hold.
- `core_done` in 1: core done flag (sticky in core).
- `res_valid` out 1: result byte available.
- `res_ready` in 1: host accepts result.
- `res_data` out 8: result byte.
- `res_index` out 8: offset of `res_data` within window, 0..RES_COUNT-1.
- `busy` out 1: high in every state except IDLE.
- `fault` out 1: sticky watchdog fault, cleared only by `reset`.

## Operation
- States: IDLE, START, RUN, FETCH, SEND.
- IDLE:
  - `load_ready`=1; `mem_we`=`load_valid`; `mem_addr`=`load_addr`; `mem_wdata`=`load_data` (combinational pass-through).
  - `go`=1 → START. A load offered in the same cycle is still written.
- START:
  - `core_start`=1 for exactly START_CYCLES cycles; `load_ready`=0; then → RUN.
  - `core_done` is ignored in START because the core clears done via start.
- RUN:
  - `core_start`=0; watchdog counts from 0, one increment per RUN cycle.
  - `core_done`=1 → FETCH with index=0.
  - Count reaching TIMEOUT-1 without `core_done` → `fault`=1, → IDLE.
  - If `core_done` and timeout occur in the same cycle, done wins and no fault is raised.
- FETCH (1 cycle):
  - `mem_re`=1; `mem_addr`=RES_BASE+index, 8-bit wrap (e.g. 8'hFF+1 → 8'h00).
  - Register `mem_rdata` into `res_data`; → SEND.
- SEND:
  - `res_valid`=1; `res_data`/`res_index` held stable until the handshake.
  - `res_valid&res_ready` with index<RES_COUNT-1 → index+1, FETCH.
  - Handshake on the last index → IDLE.
- `mem_we`=0 outside IDLE; `mem_re`=0 outside FETCH. The core owns the memory port in START/RUN.
- `go` outside IDLE is ignored. `load_valid` outside IDLE is not accepted and stays pending.
- `reset` asserted in any state forces IDLE immediately (asynchronously) and discards any partial run or result stream.

## Timing
- Reset values:
  - 0: `core_start`, `res_valid`, `res_data`, `res_index`, `busy`, `fault`, `mem_re`, watchdog, index.
  - `load_ready`=1, state=IDLE.
- A preload write is 0-latency: combinational to the memory port, committed by memory at that edge.
- `go` sampled at edge t → `core_start` high in cycles t+1..t+START_CYCLES.
- `core_done` sampled at edge u → first `res_valid` at u+2 (FETCH, then SEND).
- Result throughput is 1 byte per 2 cycles with `res_ready` held high. A full window takes 2·RES_COUNT cycles.
- All outputs except the IDLE memory/load pass-through are registered or decoded from state.

## Configuration
- `RUN_SEQ_TIMEOUT_EN` defined: watchdog and `fault` behave as above.
- `RUN_SEQ_TIMEOUT_EN` undefined: no counter is instantiated, `fault` is tied 0, and RUN waits on `core_done` indefinitely.

## Test plan
- Preload addr 0..3 ← 8'hA1..8'hA4 back-to-back: four `mem_we` cycles with matching addr/data, `load_ready` high throughout.
- `go` with START_CYCLES=2: `core_start` high for exactly 2 cycles. Holding `core_done`=1 during START still yields RUN, and the FETCH arrives only after RUN samples done.
- Model memory [64..71]=8'h10..8'h17, `core_done` at RUN cycle 5, `res_ready`=1: 8 beats of `res_data` 8'h10..8'h17, `res_index` 0..7, 16 cycles total, then IDLE.
- `res_ready` low for 3 cycles on index 2: `res_valid`, `res_data`=8'h12 and `res_index`=2 held stable, with no extra FETCH.
- With the macro defined and TIMEOUT=16, `core_done` never asserted: `fault`=1 after 16 RUN cycles, return to IDLE, `fault` held across a later `go`. With the macro undefined, no fault occurs after 10000 cycles.
- `reset` pulsed mid-SEND at index 4: all outputs return to reset values asynchronously. After release, a new run restarts at index 0.

Source files
------------

// File: rtl/run_sequencer.sv
// Host-side run sequencer: preload, start pulse, wait for done, stream results.
// Optional watchdog enabled by defining RUN_SEQ_TIMEOUT_EN.
`timescale 1ns/1ps
module run_sequencer #(
  parameter logic [7:0] RES_BASE = 8'd64,
  parameter int RES_COUNT = 8,
  parameter int START_CYCLES = 2
`ifdef RUN_SEQ_TIMEOUT_EN
  , parameter int TIMEOUT = 4096
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load_valid,
  output logic       load_ready,
  input  logic [7:0] load_addr,
  input  logic [7:0] load_data,
  input  logic       go,
  output logic       mem_we,
  output logic       mem_re,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  input  logic [7:0] mem_rdata,
  output logic       core_start,
  input  logic       core_done,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] res_data,
  output logic [7:0] res_index,
  output logic       busy,
  output logic       fault
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_RUN, S_FETCH, S_SEND
  } state_t;

  localparam logic [7:0] ST_LAST  = 8'(START_CYCLES - 1);
  localparam logic [7:0] IDX_LAST = 8'(RES_COUNT - 1);

  state_t     state_q, state_d;
  logic [7:0] st_cnt_q, st_cnt_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] rdata_q, rdata_d;
  logic       wd_hit;

`ifdef RUN_SEQ_TIMEOUT_EN
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);
  logic [15:0] wd_q;
  logic        fault_q;

  assign wd_hit = (wd_q == WD_LAST);
  assign fault  = fault_q;

  // Watchdog counts RUN cycles; fault latches when it expires without done
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_q    <= '0;
      fault_q <= 1'b0;
    end else begin
      wd_q <= (state_q == S_RUN) ? wd_q + 16'd1 : '0;
      if (state_q == S_RUN && !core_done && wd_hit)
        fault_q <= 1'b1;
    end
  end
`else
  assign wd_hit = 1'b0;
  assign fault  = 1'b0;
`endif

  assign busy      = (state_q != S_IDLE);
  assign res_data  = rdata_q;
  assign res_index = idx_q;

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      st_cnt_q <= '0;
      idx_q    <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      st_cnt_q <= st_cnt_d;
      idx_q    <= idx_d;
      rdata_q  <= rdata_d;
    end
  end

  // Next-state and memory-port / handshake decode
  always_comb begin
    state_d    = state_q;
    st_cnt_d   = st_cnt_q;
    idx_d      = idx_q;
    rdata_d    = rdata_q;
    load_ready = 1'b0;
    mem_we     = 1'b0;
    mem_re     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    core_start = 1'b0;
    res_valid  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        load_ready = 1'b1;
        mem_we     = load_valid;
        mem_addr   = load_addr;
        mem_wdata  = load_data;
        if (go) begin
          state_d  = S_START;
          st_cnt_d = '0;
        end
      end
      S_START: begin
        core_start = 1'b1;
        if (st_cnt_q == ST_LAST) begin
          state_d  = S_RUN;
          st_cnt_d = '0;
        end else begin
          st_cnt_d = st_cnt_q + 8'd1;
        end
      end
      S_RUN: begin
        if (core_done) begin
          state_d = S_FETCH;
          idx_d   = '0;
        end else if (wd_hit) begin
          state_d = S_IDLE;
        end
      end
      S_FETCH: begin
        mem_re   = 1'b1;
        mem_addr = RES_BASE + idx_q;
        rdata_d  = mem_rdata;
        state_d  = S_SEND;
      end
      S_SEND: begin
        res_valid = 1'b1;
        if (res_ready) begin
          if (idx_q == IDX_LAST) begin
            state_d = S_IDLE;
          end else begin
            idx_d   = idx_q + 8'd1;
            state_d = S_FETCH;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_run_sequencer.sv
// Directed bench for run_sequencer with a result scoreboard.
// Covers preload, start pulse, streaming, stall, watchdog and async reset.
`timescale 1ns/1ps
module tb_run_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       load_valid, load_ready;
  logic [7:0] load_addr, load_data;
  logic       go;
  logic       mem_we, mem_re;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic       core_start, core_done;
  logic       res_valid, res_ready;
  logic [7:0] res_data, res_index;
  logic       busy, fault;

  always #5 clk = ~clk;

  run_sequencer #(
    .RES_BASE(8'd64),
    .RES_COUNT(8),
    .START_CYCLES(2)
`ifdef RUN_SEQ_TIMEOUT_EN
    , .TIMEOUT(16)
`endif
  ) dut (
    .clk(clk), .reset(reset),
    .load_valid(load_valid), .load_ready(load_ready),
    .load_addr(load_addr), .load_data(load_data),
    .go(go),
    .mem_we(mem_we), .mem_re(mem_re),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .core_start(core_start), .core_done(core_done),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_index(res_index),
    .busy(busy), .fault(fault)
  );

  logic [7:0] mem [256];
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

  int checks = 0;
  int errors = 0;
  int beats  = 0;

  typedef struct packed {
    logic [7:0] d;
    logic [7:0] i;
  } exp_t;
  exp_t sb[$];

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic smp;
    @(negedge clk);
  endtask

  task automatic push_window;
    for (int i = 0; i < 8; i++)
      sb.push_back(exp_t'{d: 8'(8'h10 + i), i: 8'(i)});
  endtask

  task automatic wait_idle(int bound);
    int n = 0;
    smp;
    while (busy !== 1'b0 && n < bound) begin
      smp;
      n++;
    end
    check("idle_reached", 32'(busy), 32'd0);
  endtask

  task automatic wait_fetch(logic [7:0] a, int bound);
    int n = 0;
    smp;
    while (!(mem_re === 1'b1 && mem_addr === a) && n < bound) begin
      smp;
      n++;
    end
    check("fetch_seen", 32'({mem_re, mem_addr}), 32'({1'b1, a}));
  endtask

  task automatic wait_valid(int bound);
    int n = 0;
    smp;
    while (res_valid !== 1'b1 && n < bound) begin
      smp;
      n++;
    end
    check("valid_seen", 32'(res_valid), 32'd1);
  endtask

  // Scoreboard: every accepted result beat is popped and compared
  always @(negedge clk) begin
    if (!reset && res_valid === 1'b1 && res_ready === 1'b1) begin
      beats++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL sb_empty observed=%0h/%0h expected=none",
               res_data, res_index);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("res_data", 32'(res_data), 32'(e.d));
        check("res_index", 32'(res_index), 32'(e.i));
      end
    end
  end

  initial begin
    reset      = 1'b1;
    load_valid = 1'b0;
    load_addr  = '0;
    load_data  = '0;
    go         = 1'b0;
    core_done  = 1'b0;
    res_ready  = 1'b0;
    repeat (2) smp;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_load_ready", 32'(load_ready), 32'd1);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_core_start", 32'(core_start), 32'd0);
    check("rst_res_index", 32'(res_index), 32'd0);
    check("rst_res_data", 32'(res_data), 32'd0);
    check("rst_mem_re", 32'(mem_re), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Preload operands and the result window, back-to-back
    for (int i = 0; i < 12; i++) begin
      load_valid = 1'b1;
      load_addr  = (i < 4) ? 8'(i) : 8'(60 + i);
      load_data  = (i < 4) ? 8'(8'hA1 + i) : 8'(8'h10 + i - 4);
      smp;
      check("pl_we", 32'(mem_we), 32'd1);
      check("pl_addr", 32'(mem_addr), 32'(load_addr));
      check("pl_wdata", 32'(mem_wdata), 32'(load_data));
      check("pl_ready", 32'(load_ready), 32'd1);
      tick;
    end
    load_valid = 1'b0;
    smp;
    check("pl_we_off", 32'(mem_we), 32'd0);
    check("pl_mem2", 32'(mem[2]), 32'hA3);
    check("pl_mem67", 32'(mem[67]), 32'h13);

    // Run 1: done held through START, full window with ready high
    go = 1'b1;
    core_done = 1'b1;
    res_ready = 1'b1;
    beats = 0;
    push_window;
    tick;
    go = 1'b0;
    load_valid = 1'b1;
    smp;
    check("st1_core_start", 32'(core_start), 32'd1);
    check("st1_busy", 32'(busy), 32'd1);
    check("st1_load_ready", 32'(load_ready), 32'd0);
    check("st1_no_we", 32'(mem_we), 32'd0);
    tick;
    load_valid = 1'b0;
    smp;
    check("st2_core_start", 32'(core_start), 32'd1);
    tick;
    smp;
    check("run_start_low", 32'(core_start), 32'd0);
    check("run_no_fetch", 32'(mem_re), 32'd0);
    check("run_busy", 32'(busy), 32'd1);
    tick;
    smp;
    check("f0_re", 32'(mem_re), 32'd1);
    check("f0_addr", 32'(mem_addr), 32'd64);
    core_done = 1'b0;
    repeat (15) tick;
    smp;
    check("last_busy", 32'(busy), 32'd1);
    check("last_valid", 32'(res_valid), 32'd1);
    check("last_index", 32'(res_index), 32'd7);
    tick;
    smp;
    check("window_16", 32'(busy), 32'd0);
    check("beats_run1", 32'(beats), 32'd8);
    check("sb_drained1", 32'(sb.size()), 32'd0);

    // Run 2: done at RUN cycle 5, stall on index 2
    go = 1'b1;
    beats = 0;
    tick;
    go = 1'b0;
    tick;
    tick;
    for (int k = 0; k < 5; k++) begin
      smp;
      check("run_wait_re", 32'(mem_re), 32'd0);
      tick;
    end
    core_done = 1'b1;
    push_window;
    tick;
    core_done = 1'b0;
    wait_fetch(8'd66, 10);
    tick;
    res_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      smp;
      check("stall_valid", 32'(res_valid), 32'd1);
      check("stall_data", 32'(res_data), 32'h12);
      check("stall_index", 32'(res_index), 32'd2);
      check("stall_no_fetch", 32'(mem_re), 32'd0);
      tick;
    end
    res_ready = 1'b1;
    wait_idle(40);
    check("beats_run2", 32'(beats), 32'd8);
    check("sb_drained2", 32'(sb.size()), 32'd0);

    // Run 3: core never finishes on its own
`ifdef RUN_SEQ_TIMEOUT_EN
    go = 1'b1;
    tick;
    go = 1'b0;
    tick;
    tick;
    repeat (15) tick;
    smp;
    check("wd_pre_busy", 32'(busy), 32'd1);
    check("wd_pre_fault", 32'(fault), 32'd0);
    tick;
    smp;
    check("wd_fault", 32'(fault), 32'd1);
    check("wd_idle", 32'(busy), 32'd0);
    go = 1'b1;
    tick;
    go = 1'b0;
    smp;
    check("wd_restart", 32'(core_start), 32'd1);
    check("fault_sticky", 32'(fault), 32'd1);
    tick;
    tick;
    core_done = 1'b1;
    beats = 0;
    push_window;
    tick;
    core_done = 1'b0;
    wait_idle(40);
    check("fault_kept", 32'(fault), 32'd1);
    check("beats_run3", 32'(beats), 32'd8);
`else
    go = 1'b1;
    tick;
    go = 1'b0;
    repeat (10000) tick;
    smp;
    check("nowd_fault", 32'(fault), 32'd0);
    check("nowd_busy", 32'(busy), 32'd1);
    check("nowd_start", 32'(core_start), 32'd0);
    core_done = 1'b1;
    beats = 0;
    push_window;
    tick;
    core_done = 1'b0;
    wait_idle(40);
    check("beats_run3", 32'(beats), 32'd8);
`endif
    check("sb_drained3", 32'(sb.size()), 32'd0);

    // Run 4: asynchronous reset mid-SEND at index 4
    go = 1'b1;
    core_done = 1'b1;
    res_ready = 1'b1;
    beats = 0;
    push_window;
    tick;
    go = 1'b0;
    wait_fetch(8'd68, 30);
    tick;
    res_ready = 1'b0;
    core_done = 1'b0;
    smp;
    check("send4_index", 32'(res_index), 32'd4);
    check("send4_beats", 32'(beats), 32'd4);
    #2 reset = 1'b1;
    #1;
    check("ar_res_valid", 32'(res_valid), 32'd0);
    check("ar_busy", 32'(busy), 32'd0);
    check("ar_res_index", 32'(res_index), 32'd0);
    check("ar_res_data", 32'(res_data), 32'd0);
    check("ar_fault", 32'(fault), 32'd0);
    check("ar_core_start", 32'(core_start), 32'd0);
    check("ar_mem_re", 32'(mem_re), 32'd0);
    check("ar_load_ready", 32'(load_ready), 32'd1);
    sb.delete();
    tick;
    reset = 1'b0;

    // Run 5: fresh run restarts the window at index 0
    go = 1'b1;
    core_done = 1'b1;
    res_ready = 1'b1;
    beats = 0;
    push_window;
    tick;
    go = 1'b0;
    wait_valid(20);
    check("rs_index0", 32'(res_index), 32'd0);
    check("rs_data0", 32'(res_data), 32'h10);
    core_done = 1'b0;
    wait_idle(40);
    check("beats_run5", 32'(beats), 32'd8);
    check("sb_drained5", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
